load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024, the depth of the word-organised data memory it drives; the word index is mem_addr[11:2].
REQ-002 The block SHALL have parameter LOG_EN, default 1: nonzero enables the simulation-only write log.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: one clock; reset is synchronous and active-low (reset==0 resets on the clk rising edge).
REQ-005 The block SHALL have port req_valid, input, 1, CPU access request.
REQ-006 The block SHALL have port req_ready, output, 1, high when a request can be accepted.
REQ-007 The block SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_size, input, 2: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 The block SHALL have port req_signed, input, 1, sign-extend sub-word loads when 1.
REQ-010 The block SHALL have ports req_addr, req_wdata and req_pc, each input, 32: byte address, store data (right-justified) and instruction PC.
REQ-011 The block SHALL have ports resp_valid, output, 1; resp_rdata, output, 32; resp_err, output, 1 (misaligned or reserved size).
REQ-012 The block SHALL have ports mem_addr, output, 32; mem_wdata, output, 32; mem_we, output, 1; mem_rdata, input, 32. The memory reads combinationally and writes on the clk edge while mem_we=1.

Function
REQ-013 The FSM SHALL have states IDLE, READ, WRITE and RESP, and req_ready SHALL be 1 only in IDLE.
REQ-014 The block SHALL accept a request on a cycle with req_valid & req_ready, capturing addr, wdata, size, signed, we and pc.
REQ-015 Misalignment SHALL be defined as a halfword with addr[0]=1, a word with addr[1:0]!=0, or size 11.
REQ-016 A misaligned request SHALL go IDLE->RESP with resp_err=1 and resp_rdata=0, and mem_we SHALL never assert for it.
REQ-017 Loads SHALL go IDLE->READ->RESP; word-store SHALL go IDLE->WRITE->RESP; byte/halfword store SHALL go IDLE->READ->WRITE->RESP (read-modify-write).
REQ-018 The block SHALL drive mem_addr = {addr[31:2],2'b00} in READ and WRITE, and 0 elsewhere.
REQ-019 READ SHALL register mem_rdata into an internal word buffer at the end of the cycle.
REQ-020 Byte lanes SHALL be little-endian: offset k selects bits 8k+7:8k, and a halfword at offset h selects bits 16h+15:16h.
REQ-021 For loads, resp_rdata SHALL be the selected lane, sign-extended if req_signed else zero-extended; word loads return the word unchanged.
REQ-022 For stores, mem_wdata in WRITE SHALL be the buffered word with only the addressed lanes replaced by the low bits of wdata, or wdata itself for word stores.
REQ-023 mem_we SHALL be 1 for exactly one cycle, in WRITE only.
REQ-024 RESP SHALL hold resp_valid=1 for exactly one cycle (resp_rdata=0 for stores), then return to IDLE.
REQ-025 Latency from the accept edge SHALL be: misaligned 1 cycle, load 2, word store 2, sub-word store 3.
REQ-026 A new request SHALL be accepted at the earliest on the cycle after RESP.
REQ-027 The block SHALL NOT buffer requests: req_valid while req_ready=0 is ignored.
REQ-028 With LOG_EN set, each WRITE SHALL print "@<pc>: *<word addr> <= <mem_wdata>" in 8-digit hex.

Reset
REQ-029 While reset=0 at a clk edge, the block SHALL go to IDLE and clear the buffer and captured fields.
REQ-030 After reset, outputs SHALL be: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-031 Reset asserted in READ or WRITE SHALL abort the access: no write occurs on that edge or later, and no response is issued.

Structure
REQ-032 A shared package SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
REQ-033 Lane extraction/extension and store merging SHALL be one combinational sub-module, byte_lane_unit.

Verification
REQ-034 Word store addr 0x10, wdata 0xDEADBEEF -> mem_we one cycle at accept+1, mem_addr 0x10; resp_valid at accept+2; log line printed.
REQ-035 Memory word 0x10 = 0x11223344, signed byte load addr 0x13 -> resp_rdata 0x00000011; signed byte load addr 0x10 -> 0x00000044; word 0x000080FF, signed half load addr 0x10 -> 0xFFFF80FF, unsigned -> 0x000080FF.
REQ-036 sb addr 0x11, wdata 0xAB over word 0x11223344 -> mem_wdata 0x1122AB44, written at accept+2, resp at accept+3.
REQ-037 Word load addr 0x12 and half store addr 0x13 -> resp_err=1 at accept+1, mem_we never asserted, memory unchanged.
REQ-038 reset=0 during the WRITE of sh addr 0x20 -> mem_we=0 on that edge, memory unchanged, req_ready=1 next cycle, no resp_valid.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule used when a request is accepted.
package load_store_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // Reserved size, odd halfword or non-word-aligned word are all rejected.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == SZ_RSVD) ||
           (size == SZ_HALF && lo[0]) ||
           (size == SZ_WORD && lo != 2'b00);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU request/response and data-memory signals of the load/store unit.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1; req_ready is 1 only while the unit is idle, and a
// req_valid seen while req_ready is 0 is simply ignored (nothing is queued).
// The response is a single-cycle resp_valid pulse with no back-pressure.
// The memory reads combinationally from mem_addr and writes on the clk edge
// while mem_we is 1.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  lsu_state_e  dbg_state;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_pc,
    input  mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, mem_we, dbg_state
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_pc,
    output mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wdata, mem_we, dbg_state
  );

endinterface

// File: rtl/load_store_unit_lane.sv
// byte_lane_unit: little-endian lane selection with sign/zero extension for
// loads, and merging of store data into a buffered word for stores.
module byte_lane_unit
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, extend it for loads, splice it in for stores.
  always_comb begin
    byte_sel   = word_in[{offset, 3'b000} +: 8];
    half_sel   = offset[1] ? word_in[31:16] : word_in[15:0];
    load_data  = '0;
    store_data = word_in;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
        store_data[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{is_signed & half_sel[15]}}, half_sel};
        if (offset[1]) store_data[31:16] = wdata[15:0];
        else           store_data[15:0]  = wdata[15:0];
      end
      SZ_WORD: begin
        load_data  = word_in;
        store_data = wdata;
      end
      default: begin
        load_data  = '0;
        store_data = word_in;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one outstanding CPU load/store against a word memory.
// Sub-word stores are done as read-modify-write; misaligned or reserved-size
// requests are answered with resp_err and never touch memory.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LOG_EN    = 1
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.slave  bus
);

  // The word index is mem_addr[11:2], so the memory cannot exceed 1024 words.
  if (MEM_WORDS < 1 || MEM_WORDS > 1024) begin : g_bad_depth
    $error("load_store_unit: MEM_WORDS must be 1..1024");
  end

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        we_q, we_d;
  logic        err_q, err_d;

  logic [31:0] load_data;
  logic [31:0] store_data;

  byte_lane_unit u_lane (
    .word_in    (buf_q),
    .offset     (addr_q[1:0]),
    .size       (size_q),
    .is_signed  (signed_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // Next-state and capture logic for the access sequencer.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pc_d     = pc_q;
    buf_d    = buf_q;
    size_d   = size_q;
    signed_d = signed_q;
    we_d     = we_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          pc_d     = bus.req_pc;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          we_d     = bus.req_we;
          err_d    = is_misaligned(bus.req_size, bus.req_addr[1:0]);
          buf_d    = '0;
          if (is_misaligned(bus.req_size, bus.req_addr[1:0])) state_d = RESP;
          else if (!bus.req_we)                               state_d = READ;
          else if (bus.req_size == SZ_WORD)                   state_d = WRITE;
          else                                                state_d = READ;
        end
      end
      READ: begin
        buf_d   = bus.mem_rdata;
        state_d = we_q ? WRITE : RESP;
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured request fields; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      pc_q     <= '0;
      buf_q    <= '0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      pc_q     <= pc_d;
      buf_q    <= buf_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      we_q     <= we_d;
      err_q    <= err_d;
    end
  end

  // Outputs decode only registered state. mem_we is also gated by reset so a
  // reset landing on the WRITE cycle suppresses the write on that same edge.
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = (state_q == RESP) && err_q;
  assign bus.resp_rdata = (state_q == RESP && !err_q && !we_q) ? load_data : '0;
  assign bus.mem_addr   = (state_q == READ || state_q == WRITE) ? {addr_q[31:2], 2'b00} : '0;
  assign bus.mem_we     = (state_q == WRITE) && reset;
  assign bus.mem_wdata  = (state_q == WRITE) ? store_data : '0;
  assign bus.dbg_state  = state_q;

`ifndef SYNTHESIS
  // Simulation write log: one line per memory write.
  always @(posedge clk) begin
    if (LOG_EN != 0 && bus.mem_we)
      $display("@%08h: *%08h <= %08h", pc_q, bus.mem_addr, bus.mem_wdata);
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: fixed vector table, random accesses checked
// against a small reference model, and hand-written reset-abort sequences.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int MEM_WORDS = 1024;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pre;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] post;
    int          lat;
    int          wr_k;
  } vec_t;

  // Clock and reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_WORDS(MEM_WORDS), .LOG_EN(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model with a backdoor preload port
  logic [31:0] mem [MEM_WORDS];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  assign bus.mem_rdata = mem[bus.mem_addr[11:2]];

  always @(posedge clk) begin
    if (bus.mem_we)  mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
    else if (bd_we)  mem[bd_idx] <= bd_data;
  end

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: resp_valid=1 rdata %h with no request outstanding", bus.resp_rdata);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("resp_err", 32'(bus.resp_err), 32'(e[32]));
        chk("resp_rdata", bus.resp_rdata, e[31:0]);
      end
    end
  end

  // Driver tasks
  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_data = data;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_pc     = 32'h0000_1000 + 32'($urandom_range(0, 255)) * 4;
  endtask

  task automatic run_req(input vec_t v, input string tag);
    logic [9:0] idx;
    int got;
    int wr_cnt;
    int wr_k;
    bit hold;
    idx = v.addr[11:2];
    got = 0; wr_cnt = 0; wr_k = 0;
    hold = ($urandom_range(0, 1) == 1);
    preload(idx, v.pre);
    @(negedge clk);
    chk({tag, "_ready_idle"}, 32'(bus.req_ready), 32'd1);
    drive_req(v.we, v.size, v.sgn, v.addr, v.wdata);
    exp_q.push_back({v.err, v.rdata});
    @(posedge clk);
    #1;
    if (hold) drive_req(1'b1, SZ_WORD, 1'b0, v.addr ^ 32'h100, 32'h5A5A_5A5A);
    else      bus.req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (bus.mem_we) begin
        wr_cnt++;
        wr_k = k;
        chk({tag, "_mem_addr"}, bus.mem_addr, {v.addr[31:2], 2'b00});
        chk({tag, "_mem_wdata"}, bus.mem_wdata, v.post);
      end
      if (bus.resp_valid) begin
        got = k;
        break;
      end
      chk({tag, "_ready_busy"}, 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    if (got == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no resp_valid within 6 cycles, expected latency %0d", tag, v.lat);
      void'(exp_q.pop_back());
    end
    chk({tag, "_latency"}, 32'(got), 32'(v.lat));
    chk({tag, "_wr_count"}, 32'(wr_cnt), (v.wr_k != 0) ? 32'd1 : 32'd0);
    chk({tag, "_wr_cycle"}, 32'(wr_k), 32'(v.wr_k));
    chk({tag, "_mem_word"}, mem[idx], v.post);
    @(negedge clk);
    chk({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_resp_one_cycle"}, 32'(bus.resp_valid), 32'd0);
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] pre, input logic err,
                              input logic [31:0] rdata, input logic [31:0] post,
                              input int lat, input int wr_k);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.pre = pre; v.err = err; v.rdata = rdata; v.post = post;
    v.lat = lat; v.wr_k = wr_k;
    return v;
  endfunction

  // Reference model: shift/mask arithmetic on the whole word
  function automatic vec_t model(input logic we, input logic [1:0] sz, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] pre);
    vec_t v;
    logic [31:0] mask;
    logic [31:0] val;
    int sh;
    v.we = we; v.size = sz; v.sgn = sgn; v.addr = addr; v.wdata = wdata; v.pre = pre;
    v.post = pre; v.rdata = '0; v.wr_k = 0;
    sh = int'(addr[1:0]) * 8;
    mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    v.err = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
    if (v.err) begin
      v.lat = 1;
    end else if (!we) begin
      val = (pre >> sh) & mask;
      if (sgn && sz == 2'd0 && val[7])  val = val | 32'hFFFF_FF00;
      if (sgn && sz == 2'd1 && val[15]) val = val | 32'hFFFF_0000;
      v.rdata = val;
      v.lat = 2;
    end else begin
      v.post = (pre & ~(mask << sh)) | ((wdata & mask) << sh);
      v.lat = (sz == 2'd2) ? 2 : 3;
      v.wr_k = v.lat - 1;
    end
    return v;
  endfunction

  vec_t vecs[16];

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_BYTE;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_pc = '0;

    //       we    size     sgn   addr         wdata          pre            err   rdata          post           lat wr
    vecs[0]  = mk(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0000_0000, 1'b0, 32'h0,         32'hDEADBEEF, 2, 1);
    vecs[1]  = mk(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0,        32'h1122_3344, 1'b0, 32'h0000_0011, 32'h11223344, 2, 0);
    vecs[2]  = mk(1'b0, SZ_BYTE, 1'b1, 32'h10, 32'h0,        32'h1122_3344, 1'b0, 32'h0000_0044, 32'h11223344, 2, 0);
    vecs[3]  = mk(1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0,        32'h0000_80FF, 1'b0, 32'hFFFF_80FF, 32'h000080FF, 2, 0);
    vecs[4]  = mk(1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0,        32'h0000_80FF, 1'b0, 32'h0000_80FF, 32'h000080FF, 2, 0);
    vecs[5]  = mk(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'hAB,       32'h1122_3344, 1'b0, 32'h0,         32'h1122AB44, 3, 2);
    vecs[6]  = mk(1'b0, SZ_WORD, 1'b0, 32'h12, 32'h0,        32'h1122_3344, 1'b1, 32'h0,         32'h11223344, 1, 0);
    vecs[7]  = mk(1'b1, SZ_HALF, 1'b0, 32'h13, 32'hBEEF,     32'h1122_3344, 1'b1, 32'h0,         32'h11223344, 1, 0);
    vecs[8]  = mk(1'b0, SZ_BYTE, 1'b1, 32'h12, 32'h0,        32'h0080_0000, 1'b0, 32'hFFFF_FF80, 32'h00800000, 2, 0);
    vecs[9]  = mk(1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0,        32'h0080_0000, 1'b0, 32'h0000_0080, 32'h00800000, 2, 0);
    vecs[10] = mk(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0,        32'h8001_1234, 1'b0, 32'hFFFF_8001, 32'h80011234, 2, 0);
    vecs[11] = mk(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h1234CAFE, 32'hAAAA_BBBB, 1'b0, 32'h0,         32'hCAFEBBBB, 3, 2);
    vecs[12] = mk(1'b0, SZ_RSVD, 1'b0, 32'h10, 32'h0,        32'h1122_3344, 1'b1, 32'h0,         32'h11223344, 1, 0);
    vecs[13] = mk(1'b0, SZ_WORD, 1'b1, 32'h24, 32'h0,        32'h0123_4567, 1'b0, 32'h0123_4567, 32'h01234567, 2, 0);
    vecs[14] = mk(1'b1, SZ_BYTE, 1'b0, 32'h27, 32'h0000_00FF, 32'h0000_0000, 1'b0, 32'h0,        32'hFF000000, 3, 2);
    vecs[15] = mk(1'b1, SZ_RSVD, 1'b0, 32'h30, 32'h1234_5678, 32'h0BAD_F00D, 1'b1, 32'h0,        32'h0BADF00D, 1, 0);

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    reset = 1'b1;

    // Table vectors
    for (int i = 0; i < 16; i++) run_req(vecs[i], $sformatf("vec%0d", i));

    // Random accesses against the reference model
    for (int i = 0; i < 24; i++) begin
      vec_t v;
      v = model($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                32'($urandom_range(32'h40, 32'h7F)), $urandom, $urandom);
      run_req(v, $sformatf("rnd%0d", i));
    end

    // Reset during the WRITE of a halfword store to 0x20
    preload(10'd8, 32'h5566_7788);
    @(negedge clk);
    drive_req(1'b1, SZ_HALF, 1'b0, 32'h20, 32'h0000_9999);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_w_in_read", 32'(bus.dbg_state), 32'(READ));
    @(negedge clk);
    chk("abort_w_in_write", 32'(bus.dbg_state), 32'(WRITE));
    reset = 1'b0;
    #1 chk("abort_w_mem_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    chk("abort_w_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_w_resp", 32'(bus.resp_valid), 32'd0);
    chk("abort_w_mem", mem[8], 32'h5566_7788);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_w_quiet_resp", 32'(bus.resp_valid), 32'd0);
      chk("abort_w_quiet_we", 32'(bus.mem_we), 32'd0);
    end
    chk("abort_w_mem_later", mem[8], 32'h5566_7788);

    // Reset during the READ of a word load: no response afterwards
    drive_req(1'b0, SZ_WORD, 1'b0, 32'h24, 32'h0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_r_in_read", 32'(bus.dbg_state), 32'(READ));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_r_ready", 32'(bus.req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("abort_r_quiet_resp", 32'(bus.resp_valid), 32'd0);
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
